// File: rtl/mem_port_arbiter.sv
// Round-robin arbiter sharing one cache-line memory port between the I-cache
// (read-only) and the D-cache (read/write); one downstream transaction at a time.
module mem_port_arbiter #(
  parameter int unsigned XLEN    = 32,
  parameter int unsigned CLSIZE  = 128,
  parameter bit          D_FIRST = 1'b1
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              i_strobe_i,
  input  logic [XLEN-1:0]   i_addr_i,
  output logic              i_done_o,
  output logic [CLSIZE-1:0] i_data_o,
  input  logic              d_strobe_i,
  input  logic [XLEN-1:0]   d_addr_i,
  input  logic              d_rw_i,
  input  logic [CLSIZE-1:0] d_data_i,
  output logic              d_done_o,
  output logic [CLSIZE-1:0] d_data_o,
  output logic              m_strobe_o,
  output logic [XLEN-1:0]   m_addr_o,
  output logic              m_rw_o,
  output logic [CLSIZE-1:0] m_data_o,
  input  logic              m_done_i,
  input  logic [CLSIZE-1:0] m_data_i,
  output logic              owner_o,
  output logic              busy_o
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    BUSY_I = 2'd1,
    BUSY_D = 2'd2
  } state_t;

  state_t state, state_next;

  logic              last_owner;   // 1 = D was granted most recently
  logic              pend_i, pend_d;
  logic [XLEN-1:0]   i_addr_q, d_addr_q;
  logic              d_rw_q;
  logic [CLSIZE-1:0] d_data_q;

  logic acc_i, acc_d, req_i, req_d;
  logic grant_i, grant_d;
  logic finish, finish_i, finish_d;

  // A port never re-requests while it has one pending or in service.
  always_comb begin
    acc_i = i_strobe_i & ~pend_i & (state != BUSY_I);
    acc_d = d_strobe_i & ~pend_d & (state != BUSY_D);
    req_i = pend_i | acc_i;
    req_d = pend_d | acc_d;
  end

  // A completion in the request cycle itself cannot belong to this transaction.
  always_comb begin
    finish   = m_done_i & (state != IDLE) & ~m_strobe_o;
    finish_i = finish & (state == BUSY_I);
    finish_d = finish & (state == BUSY_D);
  end

  always_comb begin
    state_next = state;
    grant_i    = 1'b0;
    grant_d    = 1'b0;
    case (state)
      IDLE: begin
        if (req_i && req_d) begin
          grant_i = last_owner;
          grant_d = ~last_owner;
        end else begin
          grant_i = req_i;
          grant_d = req_d;
        end
        if (grant_i) state_next = BUSY_I;
        if (grant_d) state_next = BUSY_D;
      end
      BUSY_I, BUSY_D: begin
        if (finish) state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state      <= IDLE;
      last_owner <= ~D_FIRST;
      m_strobe_o <= 1'b0;
    end else begin
      state      <= state_next;
      m_strobe_o <= grant_i | grant_d;
      if (grant_i) last_owner <= 1'b0;
      if (grant_d) last_owner <= 1'b1;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      pend_i   <= 1'b0;
      pend_d   <= 1'b0;
      i_addr_q <= '0;
      d_addr_q <= '0;
      d_rw_q   <= 1'b0;
      d_data_q <= '0;
    end else begin
      if (acc_i) begin
        pend_i   <= 1'b1;
        i_addr_q <= i_addr_i;
      end else if (finish_i) begin
        pend_i <= 1'b0;
      end
      if (acc_d) begin
        pend_d   <= 1'b1;
        d_addr_q <= d_addr_i;
        d_rw_q   <= d_rw_i;
        d_data_q <= d_data_i;
      end else if (finish_d) begin
        pend_d <= 1'b0;
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      i_done_o <= 1'b0;
      d_done_o <= 1'b0;
      i_data_o <= '0;
      d_data_o <= '0;
    end else begin
      i_done_o <= finish_i;
      d_done_o <= finish_d;
      if (finish_i) i_data_o <= m_data_i;
      if (finish_d) d_data_o <= m_data_i;
    end
  end

  always_comb begin
    busy_o   = (state != IDLE);
    owner_o  = (state == BUSY_D);
    m_rw_o   = (state == BUSY_D) & d_rw_q;
    m_addr_o = '0;
    m_data_o = '0;
    if (state == BUSY_I) m_addr_o = i_addr_q;
    if (state == BUSY_D) begin
      m_addr_o = d_addr_q;
      m_data_o = d_data_q;
    end
  end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Bench for mem_port_arbiter: directed scenarios followed by a randomized run
// checked against a request-queue reference model.
module tb_mem_port_arbiter;

  localparam int unsigned XLEN   = 32;
  localparam int unsigned CLSIZE = 128;

  logic              clk_i = 1'b0;
  logic              rst_i;
  logic              i_strobe_i;
  logic [XLEN-1:0]   i_addr_i;
  logic              i_done_o;
  logic [CLSIZE-1:0] i_data_o;
  logic              d_strobe_i;
  logic [XLEN-1:0]   d_addr_i;
  logic              d_rw_i;
  logic [CLSIZE-1:0] d_data_i;
  logic              d_done_o;
  logic [CLSIZE-1:0] d_data_o;
  logic              m_strobe_o;
  logic [XLEN-1:0]   m_addr_o;
  logic              m_rw_o;
  logic [CLSIZE-1:0] m_data_o;
  logic              m_done_i;
  logic [CLSIZE-1:0] m_data_i;
  logic              owner_o;
  logic              busy_o;

  int unsigned n_cmp = 0;
  int unsigned n_bad = 0;

  mem_port_arbiter #(.XLEN(XLEN), .CLSIZE(CLSIZE), .D_FIRST(1'b1)) dut (
    .clk_i(clk_i), .rst_i(rst_i),
    .i_strobe_i(i_strobe_i), .i_addr_i(i_addr_i), .i_done_o(i_done_o), .i_data_o(i_data_o),
    .d_strobe_i(d_strobe_i), .d_addr_i(d_addr_i), .d_rw_i(d_rw_i), .d_data_i(d_data_i),
    .d_done_o(d_done_o), .d_data_o(d_data_o),
    .m_strobe_o(m_strobe_o), .m_addr_o(m_addr_o), .m_rw_o(m_rw_o), .m_data_o(m_data_o),
    .m_done_i(m_done_i), .m_data_i(m_data_i),
    .owner_o(owner_o), .busy_o(busy_o)
  );

  always #5 clk_i = ~clk_i;

  task automatic chk(input string tag, input logic [CLSIZE-1:0] obs, input logic [CLSIZE-1:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk_i);
    #1;
  endtask

  task automatic quiet();
    i_strobe_i = 1'b0;
    d_strobe_i = 1'b0;
    m_done_i   = 1'b0;
  endtask

  function automatic logic [CLSIZE-1:0] rnd128();
    return {$urandom(), $urandom(), $urandom(), $urandom()};
  endfunction

  // Reference model: one outstanding request per port (index 0 = I, 1 = D)
  bit                out_q [2];
  logic [XLEN-1:0]   q_addr[2];
  bit                q_rw  [2];
  logic [CLSIZE-1:0] q_data[2];
  bit                snap  [2];
  bit                exp_done[2];
  bit                next_done[2];
  logic [CLSIZE-1:0] exp_data[2];
  bit                inflight, cur, last, exp_strobe, own;
  int unsigned       age, due;

  task automatic rnd_cycle(input bit allow_req);
    quiet();
    next_done[0] = 1'b0;
    next_done[1] = 1'b0;
    if (inflight) begin
      if (age == 0) begin
        if ($urandom_range(0, 5) == 0) begin
          m_done_i = 1'b1;
          m_data_i = rnd128();
        end
      end else if (age == due) begin
        m_done_i = 1'b1;
        m_data_i = rnd128();
        next_done[cur] = 1'b1;
        exp_data[cur]  = m_data_i;
      end
      age++;
    end else if ($urandom_range(0, 7) == 0) begin
      m_done_i = 1'b1;
      m_data_i = rnd128();
    end
    if (!out_q[0]) begin
      if (allow_req && $urandom_range(0, 2) == 0) begin
        i_strobe_i = 1'b1;
        i_addr_i   = $urandom();
        q_addr[0]  = i_addr_i;
        q_rw[0]    = 1'b0;
        out_q[0]   = 1'b1;
      end
    end else if ($urandom_range(0, 9) == 0) begin
      i_strobe_i = 1'b1;
      i_addr_i   = $urandom();
    end
    if (!out_q[1]) begin
      if (allow_req && $urandom_range(0, 2) == 0) begin
        d_strobe_i = 1'b1;
        d_addr_i   = $urandom();
        d_rw_i     = 1'($urandom_range(0, 1));
        d_data_i   = rnd128();
        q_addr[1]  = d_addr_i;
        q_rw[1]    = d_rw_i;
        q_data[1]  = d_data_i;
        out_q[1]   = 1'b1;
      end
    end else if ($urandom_range(0, 9) == 0) begin
      d_strobe_i = 1'b1;
      d_addr_i   = $urandom();
      d_rw_i     = 1'($urandom_range(0, 1));
      d_data_i   = rnd128();
    end
    exp_strobe  = !inflight && (out_q[0] || out_q[1]);
    snap[0]     = out_q[0];
    snap[1]     = out_q[1];
    exp_done[0] = next_done[0];
    exp_done[1] = next_done[1];
    cyc();
    chk("rnd_m_strobe", m_strobe_o, exp_strobe);
    if (exp_strobe) begin
      own = (snap[0] && snap[1]) ? !last : snap[1];
      chk("rnd_grant_owner", owner_o, own);
      chk("rnd_m_addr", m_addr_o, q_addr[own]);
      chk("rnd_m_rw", m_rw_o, q_rw[own]);
      if (own) chk("rnd_m_data", m_data_o, q_data[1]);
      inflight = 1'b1;
      cur      = own;
      last     = own;
      age      = 0;
      due      = $urandom_range(1, 4);
    end
    chk("rnd_i_done", i_done_o, exp_done[0]);
    chk("rnd_d_done", d_done_o, exp_done[1]);
    chk("rnd_i_data", i_data_o, exp_data[0]);
    chk("rnd_d_data", d_data_o, exp_data[1]);
    for (int unsigned x = 0; x < 2; x++) begin
      if (exp_done[x]) begin
        out_q[x] = 1'b0;
        inflight = 1'b0;
      end
    end
    chk("rnd_busy", busy_o, inflight);
    if (inflight) chk("rnd_owner", owner_o, cur);
  endtask

  localparam logic [CLSIZE-1:0] LINE_A  = 128'h0123_4567_89AB_CDEF_FEDC_BA98_7654_3210;
  localparam logic [CLSIZE-1:0] LINE_WR = 128'hDEAD_BEEF_DEAD_BEEF_DEAD_BEEF_DEAD_BEEF;

  logic [CLSIZE-1:0] resp;
  logic [XLEN-1:0]   ia, da;
  int unsigned       strobes;
  bit                exp_own;

  initial begin
    rst_i = 1'b1;
    quiet();
    i_addr_i = '0; d_addr_i = '0; d_rw_i = 1'b0; d_data_i = '0; m_data_i = '0;

    // Reset state
    cyc(); cyc();
    chk("rst_m_strobe", m_strobe_o, 1'b0);
    chk("rst_busy", busy_o, 1'b0);
    chk("rst_owner", owner_o, 1'b0);
    chk("rst_i_done", i_done_o, 1'b0);
    chk("rst_d_done", d_done_o, 1'b0);
    chk("rst_i_data", i_data_o, '0);
    chk("rst_d_data", d_data_o, '0);
    chk("rst_m_addr", m_addr_o, '0);
    chk("rst_m_rw", m_rw_o, 1'b0);
    chk("rst_m_data", m_data_o, '0);
    rst_i = 1'b0;
    cyc();

    // I read alone, m_done 5 cycles after the strobe
    i_strobe_i = 1'b1; i_addr_i = 32'h8000_0040;
    cyc(); quiet();
    chk("t1_m_strobe", m_strobe_o, 1'b1);
    chk("t1_m_rw", m_rw_o, 1'b0);
    chk("t1_m_addr", m_addr_o, 32'h8000_0040);
    chk("t1_owner", owner_o, 1'b0);
    cyc();
    chk("t1_m_strobe_once", m_strobe_o, 1'b0);
    cyc(); cyc(); cyc();
    chk("t1_addr_stable", m_addr_o, 32'h8000_0040);
    m_done_i = 1'b1; m_data_i = LINE_A;
    cyc(); quiet();
    chk("t1_i_done", i_done_o, 1'b1);
    chk("t1_i_data", i_data_o, LINE_A);
    chk("t1_d_done", d_done_o, 1'b0);
    chk("t1_busy", busy_o, 1'b0);
    cyc();
    chk("t1_i_done_pulse", i_done_o, 1'b0);
    chk("t1_i_data_held", i_data_o, LINE_A);

    // D write
    d_strobe_i = 1'b1; d_addr_i = 32'h8000_1000; d_rw_i = 1'b1; d_data_i = LINE_WR;
    cyc(); quiet();
    chk("t2_m_strobe", m_strobe_o, 1'b1);
    chk("t2_m_rw", m_rw_o, 1'b1);
    chk("t2_m_addr", m_addr_o, 32'h8000_1000);
    chk("t2_m_data", m_data_o, LINE_WR);
    chk("t2_owner", owner_o, 1'b1);
    cyc();
    m_done_i = 1'b1; m_data_i = ~LINE_A;
    cyc(); quiet();
    chk("t2_d_done", d_done_o, 1'b1);
    chk("t2_d_data", d_data_o, ~LINE_A);
    chk("t2_i_done", i_done_o, 1'b0);
    cyc();
    chk("t2_d_done_once", d_done_o, 1'b0);
    chk("t2_i_data_kept", i_data_o, LINE_A);

    // Tie after reset: D first, I granted two cycles after D's m_done
    rst_i = 1'b1; cyc(); rst_i = 1'b0;
    i_strobe_i = 1'b1; i_addr_i = 32'h0000_1240;
    d_strobe_i = 1'b1; d_addr_i = 32'h0000_5580; d_rw_i = 1'b0;
    cyc(); quiet();
    chk("t3_m_strobe_d", m_strobe_o, 1'b1);
    chk("t3_owner_d", owner_o, 1'b1);
    chk("t3_m_addr_d", m_addr_o, 32'h0000_5580);
    cyc();
    m_done_i = 1'b1; m_data_i = 128'h11;
    cyc(); quiet();
    chk("t3_d_done", d_done_o, 1'b1);
    chk("t3_d_data", d_data_o, 128'h11);
    chk("t3_gap", m_strobe_o, 1'b0);
    cyc();
    chk("t3_m_strobe_i", m_strobe_o, 1'b1);
    chk("t3_owner_i", owner_o, 1'b0);
    chk("t3_m_addr_i", m_addr_o, 32'h0000_1240);
    cyc();
    m_done_i = 1'b1; m_data_i = 128'h22;
    cyc(); quiet();
    chk("t3_i_done", i_done_o, 1'b1);
    chk("t3_i_data", i_data_o, 128'h22);

    // Fairness: both ports refill on every completion
    ia = 32'h0000_2000; da = 32'h0000_3000;
    i_strobe_i = 1'b1; i_addr_i = ia;
    d_strobe_i = 1'b1; d_addr_i = da; d_rw_i = 1'b0;
    cyc(); quiet();
    for (int unsigned k = 0; k < 4; k++) begin
      exp_own = (k % 2 == 0);
      chk("t4_m_strobe", m_strobe_o, 1'b1);
      chk("t4_owner", owner_o, exp_own);
      chk("t4_m_addr", m_addr_o, exp_own ? da : ia);
      cyc(); cyc();
      resp = rnd128();
      m_done_i = 1'b1; m_data_i = resp;
      cyc(); quiet();
      chk("t4_done", exp_own ? d_done_o : i_done_o, 1'b1);
      chk("t4_data", exp_own ? d_data_o : i_data_o, resp);
      if (exp_own) begin
        da = da + 32'h40; d_strobe_i = 1'b1; d_addr_i = da;
      end else begin
        ia = ia + 32'h40; i_strobe_i = 1'b1; i_addr_i = ia;
      end
      cyc(); quiet();
    end

    // Reset two cycles into BUSY_D with I pending
    chk("t5_m_strobe_d", m_strobe_o, 1'b1);
    chk("t5_owner_d", owner_o, 1'b1);
    cyc();
    rst_i = 1'b1;
    cyc(); rst_i = 1'b0;
    chk("t5_busy_rst", busy_o, 1'b0);
    chk("t5_d_data_rst", d_data_o, '0);
    m_done_i = 1'b1; m_data_i = 128'h33;
    cyc(); quiet();
    chk("t5_no_d_done", d_done_o, 1'b0);
    chk("t5_no_i_done", i_done_o, 1'b0);
    chk("t5_no_strobe", m_strobe_o, 1'b0);
    cyc();
    chk("t5_pend_dropped", m_strobe_o, 1'b0);
    chk("t5_idle", busy_o, 1'b0);
    i_strobe_i = 1'b1; i_addr_i = 32'h0000_4400;
    cyc(); quiet();
    chk("t5_fresh_strobe", m_strobe_o, 1'b1);
    chk("t5_fresh_addr", m_addr_o, 32'h0000_4400);
    m_done_i = 1'b0;
    cyc();
    m_done_i = 1'b1; m_data_i = 128'h44;
    cyc(); quiet();
    chk("t5_fresh_done", i_done_o, 1'b1);
    chk("t5_fresh_data", i_data_o, 128'h44);

    // Stray completions and duplicate I strobes
    m_done_i = 1'b1; m_data_i = 128'h55;
    cyc(); quiet();
    chk("t6_idle_done_i", i_done_o, 1'b0);
    chk("t6_idle_i_data", i_data_o, 128'h44);
    chk("t6_idle_busy", busy_o, 1'b0);
    i_strobe_i = 1'b1; i_addr_i = 32'h0000_6600;
    cyc(); quiet();
    chk("t6_strobe", m_strobe_o, 1'b1);
    m_done_i = 1'b1; m_data_i = 128'h66;
    i_strobe_i = 1'b1; i_addr_i = 32'h0000_7700;
    cyc(); quiet();
    chk("t6_same_cycle_done", i_done_o, 1'b0);
    chk("t6_still_busy", busy_o, 1'b1);
    chk("t6_addr_kept", m_addr_o, 32'h0000_6600);
    chk("t6_no_restrobe", m_strobe_o, 1'b0);
    m_done_i = 1'b1; m_data_i = 128'h77;
    i_strobe_i = 1'b1; i_addr_i = 32'h0000_8800;
    cyc(); quiet();
    chk("t6_done", i_done_o, 1'b1);
    chk("t6_data", i_data_o, 128'h77);
    strobes = 0;
    for (int unsigned k = 0; k < 4; k++) begin
      cyc();
      if (m_strobe_o !== 1'b0) strobes++;
    end
    chk("t6_one_transaction", strobes, 0);
    chk("t6_final_idle", busy_o, 1'b0);

    // Randomized run against the queue model
    rst_i = 1'b1; quiet(); cyc(); rst_i = 1'b0;
    for (int unsigned x = 0; x < 2; x++) begin
      out_q[x] = 1'b0; exp_done[x] = 1'b0; exp_data[x] = '0;
    end
    inflight = 1'b0; cur = 1'b0; last = 1'b0; age = 0; due = 1;
    for (int unsigned n = 0; n < 3000; n++) begin
      if (n >= 800 && !inflight && !out_q[0] && !out_q[1]) break;
      rnd_cycle(n < 800);
    end
    quiet();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
